pipelined_control_unit: RTL and testbench
=========================================

# pipelined_control_unit

Decode-and-carry control block for the ARM pipeline. It decodes the ID-stage instruction into a packed control word and carries that word through registered EX, MEM (parametrised depth) and WB stages. It detects load-use hazards and inserts bubbles. It also honours a branch flush. It replaces the single-stage combinational decoder between the IF/ID register and the datapath.

## Interface
- ALU_OP_W, 4, width of ALU opcode field
- MEM_LAT, 1, number of MEM stages (1..4); WB follows the last one
- CLK  in  1  rising-edge clock
- CLR_N  in  1  asynchronous, active-low reset
- I  in  32  instruction in ID
- Cond_true  in  1  condition passed (present only without COND_EVAL_EN)
- NZCV  in  4  current flags (present only with COND_EVAL_EN)
- flush  in  1  taken branch resolved in EX; kill ID instruction
- ID_stall  out  1  hold PC and IF/ID this cycle
- EX_shift_imm, EX_S, EX_B_instr, EX_BL  out  1 each  EX controls
- EX_ALU_Op  out  ALU_OP_W  EX ALU opcode
- MEM_size, MEM_enable, MEM_rw, MEM_Load_Inst  out  1 each  controls of first MEM stage
- WB_RF_enable  out  1; WB_Rd  out  4  register write control

## Operation
- NOP control word = all zero. It is produced when I==0, the condition fails, the class is unlisted, or a stall or flush is active.
- Decode of I[27:25]:
  - 000 (DP register/shift):
    - ALU_Op=I[24:21], S=I[20], Rd=I[15:12].
    - shift_imm=(I[11:4]!=0).
    - RF_enable=1 except opcodes 10xx (TST/TEQ/CMP/CMN)=0.
    - Sources Rn=I[19:16] and Rm=I[3:0]; Rs=I[11:8] is also a source if I[4]=1.
  - 001 (DP immediate): as 000 but shift_imm=1; source Rn only.
  - 010 (LS immediate):
    - shift_imm=1, ALU_Op=I[23]?0100:0010.
    - MEM_enable=1, size=I[22], Load=I[20], rw=~I[20], RF_enable=I[20].
    - Sources Rn; also Rd if store.
  - 011 (LS register): as 010 but shift_imm=(I[11:4]!=0); sources add Rm.
  - 101 (B/BL): B_instr=1, BL=I[24], ALU_Op=0100, RF_enable=I[24], Rd=14.
- Load-use hazard:
  - ID_stall=1 when a load in EX or in MEM stages 1..MEM_LAT-1 has Rd equal to any valid ID source.
  - The last MEM stage forwards, so it never causes a stall.
  - Consumer after a load therefore stalls exactly MEM_LAT cycles.
- On stall: EX loads NOP. Downstream stages always advance; there is no back-pressure.
- flush=1: EX loads NOP and ID_stall is forced 0. Flush wins over stall.

## Timing
- Decode and ID_stall are combinational from I, flags and stage registers.
- The ID control word is registered into EX at the next rising CLK.
- MEM stage k control is valid k cycles after EX.
- WB control is valid MEM_LAT+1 cycles after EX.
- CLR_N low clears every stage register to NOP immediately, asynchronously.
  - All outputs reset to 0, including ID_stall.
  - Reset mid-operation discards all in-flight words.
- Release of CLR_N is synchronised by the surrounding reset logic. The first decode is captured on the first rising edge after release.

## Configuration
- COND_EVAL_EN defined:
  - The block evaluates I[31:28] against NZCV (EQ..AL; NV treated as never).
  - It also stalls when EX holds S=1 and the ID cond != 1110, until that word leaves EX.
- COND_EVAL_EN undefined:
  - Cond_true input is used directly.
  - No flag-dependency stall is generated.

## Structure
- Shared package cu_pkg contains:
  - ctrl_word_t packed struct (shift_imm, alu_op, size, enable, rw, load, S, rf_enable, b_instr, bl, rd, is_load).
  - CTRL_NOP constant.
  - Class encodings (CLS_DP_REG=3'b000 … CLS_BRANCH=3'b101).
  - cond_t enum.
- One sub-module: control_decoder, a pure combinational mapping from I to a ctrl_word_t plus source-register valid/address.
- Stage registers, hazard compare and condition check live in the top.

## Test plan
- ADD R1,R2,R3 (0xE0821003), MEM_LAT=1 → next cycle EX_ALU_Op=0100, EX_shift_imm=0; 2 cycles later WB_RF_enable=1, WB_Rd=1.
- LDR R1,[R2,#4] (0xE5921004) then ADD R3,R1,R1 (0xE0813001):
  - MEM_LAT=1 → ID_stall=1 for 1 cycle, one EX bubble.
  - MEM_LAT=3 → stall for 3 cycles.
- STR R1,[R2,#-4] (0xE5021004) → EX_ALU_Op=0010; MEM_enable=1, MEM_rw=1, MEM_Load_Inst=0; WB_RF_enable=0.
- BL (0xEB000010) → EX_B_instr=1, EX_BL=1, later WB_Rd=14, WB_RF_enable=1. flush asserted together with a load-use stall → EX=NOP, ID_stall=0.
- BEQ (0x0A000004):
  - With COND_EVAL_EN: NZCV=0000 → NOP; NZCV=0100 → EX_B_instr=1.
  - Without COND_EVAL_EN: Cond_true=0 → NOP.
- CLR_N pulsed low mid-stream with words in all stages → all outputs 0 before the next edge; a clean decode of ADD resumes after release.

Source files
------------

// File: rtl/cu_pkg.sv
// cu_pkg: shared types for the pipelined control unit.
// Holds the packed control word, its NOP value, instruction class codes,
// ARM condition codes and small helper functions used by decode and hazard logic.
package cu_pkg;

   localparam int ALU_W = 4;

   // Control word decoded in ID and carried into EX
   typedef struct packed {
      logic             shift_imm;
      logic [ALU_W-1:0] alu_op;
      logic             size;
      logic             enable;
      logic             rw;
      logic             load;
      logic             s;
      logic             rf_enable;
      logic             b_instr;
      logic             bl;
      logic [3:0]       rd;
      logic             is_load;
   } ctrl_word_t;

   // Subset of the word still needed once it leaves EX
   typedef struct packed {
      logic       size;
      logic       enable;
      logic       rw;
      logic       load;
      logic       rf_enable;
      logic [3:0] rd;
   } mem_word_t;

   localparam ctrl_word_t CTRL_NOP = '0;
   localparam mem_word_t  MEM_NOP  = '0;

   localparam logic [2:0] CLS_DP_REG = 3'b000;
   localparam logic [2:0] CLS_DP_IMM = 3'b001;
   localparam logic [2:0] CLS_LS_IMM = 3'b010;
   localparam logic [2:0] CLS_LS_REG = 3'b011;
   localparam logic [2:0] CLS_BRANCH = 3'b101;

   typedef enum logic [3:0] {
      COND_EQ = 4'h0, COND_NE, COND_CS, COND_CC, COND_MI, COND_PL, COND_VS, COND_VC,
      COND_HI, COND_LS, COND_GE, COND_LT, COND_GT, COND_LE, COND_AL, COND_NV
   } cond_t;

   // ARM condition check; NV is treated as never
   function automatic logic cond_pass(input cond_t c, input logic [3:0] nzcv);
      logic n, z, cf, v, r;
      {n, z, cf, v} = nzcv;
      case (c)
         COND_EQ: r = z;
         COND_NE: r = !z;
         COND_CS: r = cf;
         COND_CC: r = !cf;
         COND_MI: r = n;
         COND_PL: r = !n;
         COND_VS: r = v;
         COND_VC: r = !v;
         COND_HI: r = cf && !z;
         COND_LS: r = !cf || z;
         COND_GE: r = (n == v);
         COND_LT: r = (n != v);
         COND_GT: r = !z && (n == v);
         COND_LE: r = z || (n != v);
         COND_AL: r = 1'b1;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   // True when a load with destination rd feeds any valid ID source
   function automatic logic src_hit(input logic is_ld, input logic [3:0] rd,
                                    input logic [2:0] vld, input logic [2:0][3:0] addr);
      logic h;
      h = 1'b0;
      for (int j = 0; j < 3; j++) h = h | (vld[j] && (addr[j] == rd));
      return is_ld && h;
   endfunction

   function automatic mem_word_t to_mem(input ctrl_word_t w);
      mem_word_t m;
      m.size      = w.size;
      m.enable    = w.enable;
      m.rw        = w.rw;
      m.load      = w.load;
      m.rf_enable = w.rf_enable;
      m.rd        = w.rd;
      return m;
   endfunction

endpackage

// File: rtl/control_decoder.sv
// control_decoder: combinational map from an ID instruction to a control word
// plus up to three source registers (slot 0 Rn, slot 1 Rm, slot 2 Rs or store Rd).
module control_decoder
   import cu_pkg::*;
(
   input  logic [31:0]     instr,
   output ctrl_word_t      cw,
   output logic [2:0]      src_vld,
   output logic [2:0][3:0] src_addr
);

   logic [2:0] cls;
   assign cls = instr[27:25];

   // Class decode; anything unlisted or an all-zero word stays NOP
   always_comb begin
      cw          = CTRL_NOP;
      src_vld     = '0;
      src_addr[0] = instr[19:16];
      src_addr[1] = instr[3:0];
      src_addr[2] = instr[11:8];
      if (instr != 32'h0) begin
         case (cls)
            CLS_DP_REG, CLS_DP_IMM: begin
               cw.alu_op    = instr[24:21];
               cw.s         = instr[20];
               cw.rd        = instr[15:12];
               cw.shift_imm = (cls == CLS_DP_IMM) || (instr[11:4] != 8'h0);
               // TST/TEQ/CMP/CMN only set flags
               cw.rf_enable = (instr[24:23] != 2'b10);
               src_vld[0]   = 1'b1;
               if (cls == CLS_DP_REG) begin
                  src_vld[1] = 1'b1;
                  src_vld[2] = instr[4];
               end
            end
            CLS_LS_IMM, CLS_LS_REG: begin
               cw.shift_imm = (cls == CLS_LS_IMM) || (instr[11:4] != 8'h0);
               cw.alu_op    = instr[23] ? 4'b0100 : 4'b0010;
               cw.enable    = 1'b1;
               cw.size      = instr[22];
               cw.load      = instr[20];
               cw.is_load   = instr[20];
               cw.rw        = !instr[20];
               cw.rf_enable = instr[20];
               cw.rd        = instr[15:12];
               src_vld[0]   = 1'b1;
               src_vld[1]   = (cls == CLS_LS_REG);
               // a store reads its data register
               src_vld[2]   = !instr[20];
               src_addr[2]  = instr[15:12];
            end
            CLS_BRANCH: begin
               cw.b_instr   = 1'b1;
               cw.bl        = instr[24];
               cw.alu_op    = 4'b0100;
               cw.rf_enable = instr[24];
               cw.rd        = 4'd14;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit: decodes the ID instruction and carries its control
// word through EX, MEM_LAT MEM stages and WB, inserting load-use bubbles and
// honouring branch flush. Optional macro COND_EVAL_EN: evaluate the condition
// field against NZCV in this block and stall on a pending S-flag update.
module pipelined_control_unit
   import cu_pkg::*;
#(
   parameter int ALU_OP_W = 4,
   parameter int MEM_LAT  = 1
)(
   input  logic                CLK,
   input  logic                CLR_N,
   input  logic [31:0]         I,
`ifdef COND_EVAL_EN
   input  logic [3:0]          NZCV,
`else
   input  logic                Cond_true,
`endif
   input  logic                flush,
   output logic                ID_stall,
   output logic                EX_shift_imm,
   output logic                EX_S,
   output logic                EX_B_instr,
   output logic                EX_BL,
   output logic [ALU_OP_W-1:0] EX_ALU_Op,
   output logic                MEM_size,
   output logic                MEM_enable,
   output logic                MEM_rw,
   output logic                MEM_Load_Inst,
   output logic                WB_RF_enable,
   output logic [3:0]          WB_Rd
);

   ctrl_word_t      dec_cw, id_cw, ex_q;
   mem_word_t       mem_q [MEM_LAT];
   logic            wb_rf;
   logic [3:0]      wb_rd;
   logic [2:0]      src_vld, id_vld;
   logic [2:0][3:0] src_addr;
   logic            cond_ok, flag_dep, load_use, stall;
   logic [MEM_LAT-1:0] hit;

   control_decoder u_dec (
      .instr    (I),
      .cw       (dec_cw),
      .src_vld  (src_vld),
      .src_addr (src_addr)
   );

`ifdef COND_EVAL_EN
   assign cond_ok  = cond_pass(cond_t'(I[31:28]), NZCV);
   // flags written by the word in EX are not visible yet
   assign flag_dep = ex_q.s && (I[31:28] != 4'b1110) && (I != 32'h0);
`else
   assign cond_ok  = Cond_true;
   assign flag_dep = 1'b0;
`endif

   // A squashed instruction reads nothing
   assign id_cw  = cond_ok ? dec_cw : CTRL_NOP;
   assign id_vld = cond_ok ? src_vld : 3'b000;

   // Loads in EX and all but the last MEM stage cannot forward yet
   assign hit[0] = src_hit(ex_q.is_load, ex_q.rd, id_vld, src_addr);
   for (genvar k = 1; k < MEM_LAT; k++) begin : g_hit
      assign hit[k] = src_hit(mem_q[k-1].load, mem_q[k-1].rd, id_vld, src_addr);
   end

   assign load_use = |hit;
   assign stall    = load_use || flag_dep;
   assign ID_stall = stall && !flush;

   // EX register: take the ID word unless a bubble or a flush is needed
   always_ff @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N)              ex_q <= CTRL_NOP;
      else if (stall || flush) ex_q <= CTRL_NOP;
      else                     ex_q <= id_cw;
   end

   // MEM and WB stages advance every cycle
   always_ff @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N) begin
         for (int k = 0; k < MEM_LAT; k++) mem_q[k] <= MEM_NOP;
         wb_rf <= 1'b0;
         wb_rd <= 4'd0;
      end else begin
         mem_q[0] <= to_mem(ex_q);
         for (int k = 1; k < MEM_LAT; k++) mem_q[k] <= mem_q[k-1];
         wb_rf <= mem_q[MEM_LAT-1].rf_enable;
         wb_rd <= mem_q[MEM_LAT-1].rd;
      end
   end

   assign EX_shift_imm  = ex_q.shift_imm;
   assign EX_S          = ex_q.s;
   assign EX_B_instr    = ex_q.b_instr;
   assign EX_BL         = ex_q.bl;
   assign EX_ALU_Op     = ALU_OP_W'(ex_q.alu_op);
   assign MEM_size      = mem_q[0].size;
   assign MEM_enable    = mem_q[0].enable;
   assign MEM_rw        = mem_q[0].rw;
   assign MEM_Load_Inst = mem_q[0].load;
   assign WB_RF_enable  = wb_rf;
   assign WB_Rd         = wb_rd;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Bench for pipelined_control_unit: vector table with a per-stage scoreboard
// (MEM_LAT=1 instance) plus hand sequences for load-use (MEM_LAT=1 and 3),
// flush-over-stall and asynchronous reset.
module tb_pipelined_control_unit;

   logic        CLK = 1'b0;
   logic        CLR_N = 1'b0;
   logic [31:0] I = 32'h0;
   logic        ct = 1'b1;
   logic        flush = 1'b0;

   // condition stimulus: ct=1 makes EQ pass in either build
`ifdef COND_EVAL_EN
   logic [3:0] NZCV;
   assign NZCV = ct ? 4'b0100 : 4'b0000;
`endif

   logic       st1, sh1, s1, b1, bl1, msz1, men1, mrw1, mld1, wrf1;
   logic [3:0] alu1, wrd1;
   logic       st3, sh3, s3, b3, bl3, msz3, men3, mrw3, mld3, wrf3;
   logic [3:0] alu3, wrd3;

   pipelined_control_unit #(.ALU_OP_W(4), .MEM_LAT(1)) u1 (
      .CLK(CLK), .CLR_N(CLR_N), .I(I),
`ifdef COND_EVAL_EN
      .NZCV(NZCV),
`else
      .Cond_true(ct),
`endif
      .flush(flush), .ID_stall(st1),
      .EX_shift_imm(sh1), .EX_S(s1), .EX_B_instr(b1), .EX_BL(bl1), .EX_ALU_Op(alu1),
      .MEM_size(msz1), .MEM_enable(men1), .MEM_rw(mrw1), .MEM_Load_Inst(mld1),
      .WB_RF_enable(wrf1), .WB_Rd(wrd1)
   );

   pipelined_control_unit #(.ALU_OP_W(4), .MEM_LAT(3)) u3 (
      .CLK(CLK), .CLR_N(CLR_N), .I(I),
`ifdef COND_EVAL_EN
      .NZCV(NZCV),
`else
      .Cond_true(ct),
`endif
      .flush(flush), .ID_stall(st3),
      .EX_shift_imm(sh3), .EX_S(s3), .EX_B_instr(b3), .EX_BL(bl3), .EX_ALU_Op(alu3),
      .MEM_size(msz3), .MEM_enable(men3), .MEM_rw(mrw3), .MEM_Load_Inst(mld3),
      .WB_RF_enable(wrf3), .WB_Rd(wrd3)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] instr;
      logic        ct;
      logic [3:0]  alu;
      logic        sh, s, b, bl;
      logic        sz, men, rw, ld;
      logic        rf;
      logic [3:0]  rd;
   } vec_t;

   localparam int N = 13;
   localparam logic [31:0] ADD1 = 32'hE0821003;  // ADD R1,R2,R3
   localparam logic [31:0] LDR1 = 32'hE5921004;  // LDR R1,[R2,#4]
   localparam logic [31:0] ADD3 = 32'hE0813001;  // ADD R3,R1,R1
   localparam logic [31:0] BL   = 32'hEB000010;
   localparam logic [31:0] CMP6 = 32'hE3560000;  // CMP R6,#0

   vec_t tbl [N];
   vec_t sb [$];
   vec_t v, e;
   int   n_chk = 0, n_pass = 0;
   int   cnt1, cnt3;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   function automatic logic [17:0] all1();
      return {st1, sh1, s1, b1, bl1, alu1, msz1, men1, mrw1, mld1, wrf1, wrd1};
   endfunction

   function automatic logic [17:0] all3();
      return {st3, sh3, s3, b3, bl3, alu3, msz3, men3, mrw3, mld3, wrf3, wrd3};
   endfunction

   initial begin
      //            instr         ct  alu   sh s  b  bl  sz en rw ld  rf rd
      tbl[0]  = '{ADD1,         1, 4'h4, 0, 0, 0, 0,  0, 0, 0, 0,  1, 4'd1};
      tbl[1]  = '{32'hE5021004, 1, 4'h2, 1, 0, 0, 0,  0, 1, 1, 0,  0, 4'd1};   // STR R1,[R2,#-4]
      tbl[2]  = '{LDR1,         1, 4'h4, 1, 0, 0, 0,  0, 1, 0, 1,  1, 4'd1};
      tbl[3]  = '{BL,           1, 4'h4, 0, 0, 1, 1,  0, 0, 0, 0,  1, 4'd14};
      tbl[4]  = '{32'h0A000004, 1, 4'h4, 0, 0, 1, 0,  0, 0, 0, 0,  0, 4'd14};  // BEQ taken
      tbl[5]  = '{32'h0A000004, 0, 4'h0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 4'd0};   // BEQ fails
      tbl[6]  = '{32'h00821003, 0, 4'h0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 4'd0};   // ADDEQ fails
      tbl[7]  = '{CMP6,         1, 4'hA, 1, 1, 0, 0,  0, 0, 0, 0,  0, 4'd0};
      tbl[8]  = '{32'hE0887109, 1, 4'h4, 1, 0, 0, 0,  0, 0, 0, 0,  1, 4'd7};   // ADD R7,R8,R9,LSL #2
      tbl[9]  = '{32'hE7DBA00C, 1, 4'h4, 0, 0, 0, 0,  1, 1, 0, 1,  1, 4'd10};  // LDRB R10,[R11,R12]
      tbl[10] = '{32'h0,        1, 4'h0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 4'd0};
      tbl[11] = '{32'hE8BD0003, 1, 4'h0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 4'd0};   // LDM: unlisted class
      tbl[12] = '{32'hE2554001, 1, 4'h2, 1, 1, 0, 0,  0, 0, 0, 0,  1, 4'd4};   // SUBS R4,R5,#1

      // reset state
      #3;
      chk("reset_u1", 32'(all1()), 32'h0);
      chk("reset_u3", 32'(all3()), 32'h0);
      @(posedge CLK);
      @(negedge CLR_N or negedge CLK);
      CLR_N = 1'b1;
      step();

      // table through EX, MEM, WB of the MEM_LAT=1 instance
      for (int i = 0; i < N + 3; i++) begin
         if (i < N) v = tbl[i];
         else       v = '{32'h0, 1, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0};
         I  = v.instr;
         ct = v.ct;
         #1;
         chk($sformatf("stall_v%0d", i), 32'(st1), 32'h0);
         step();
         sb.push_back(v);
         e = sb[sb.size()-1];
         chk($sformatf("ex_v%0d", i), 32'({alu1, sh1, s1, b1, bl1}), 32'({e.alu, e.sh, e.s, e.b, e.bl}));
         if (sb.size() >= 2) begin
            e = sb[sb.size()-2];
            chk($sformatf("mem_v%0d", i-1), 32'({msz1, men1, mrw1, mld1}), 32'({e.sz, e.men, e.rw, e.ld}));
         end
         if (sb.size() >= 3) begin
            e = sb[sb.size()-3];
            chk($sformatf("wb_v%0d", i-2), 32'({wrf1, wrd1}), 32'({e.rf, e.rd}));
         end
         if (sb.size() > 3) void'(sb.pop_front());
      end
      ct = 1'b1;

      // load-use: one stall with MEM_LAT=1, three with MEM_LAT=3
      I = LDR1;
      step();
      I = ADD3;
      cnt1 = 0;
      cnt3 = 0;
      for (int c = 0; c < 6; c++) begin
         #1;
         cnt1 += int'(st1);
         cnt3 += int'(st3);
         if (c == 1) chk("bubble_ex", 32'({alu1, sh1, s1, b1, bl1}), 32'h0);
         if (c == 2) chk("ex_after_bubble", 32'(alu1), 32'h4);
         step();
      end
      chk("stall_cycles_lat1", 32'(cnt1), 32'd1);
      chk("stall_cycles_lat3", 32'(cnt3), 32'd3);
      I = 32'h0;
      repeat (5) step();

      // flush beats a load-use stall
      I = LDR1;
      step();
      I = ADD3;
      #1;
      chk("stall_before_flush", 32'(st1), 32'h1);
      flush = 1'b1;
      #1;
      chk("flush_stall_u1", 32'(st1), 32'h0);
      chk("flush_stall_u3", 32'(st3), 32'h0);
      step();
      chk("flush_ex_nop", 32'({alu1, sh1, s1, b1, bl1}), 32'h0);
      I = BL;
      step();
      chk("flush_bl_nop", 32'({alu1, sh1, s1, b1, bl1}), 32'h0);
      flush = 1'b0;
      step();
      chk("bl_ex", 32'({alu1, b1, bl1}), 32'h13);
      step();
      step();
      chk("bl_wb", 32'({wrf1, wrd1}), 32'h1E);
      I = 32'h0;
      repeat (5) step();

      // asynchronous reset with words in every stage
      I = ADD1; step();
      I = LDR1; step();
      I = BL;   step();
      I = CMP6; step();
      chk("prereset_wb", 32'({wrf1, wrd1}), 32'h11);
      chk("prereset_ex", 32'(alu1), 32'hA);
      #2;
      CLR_N = 1'b0;
      #1;
      chk("async_reset_u1", 32'(all1()), 32'h0);
      chk("async_reset_u3", 32'(all3()), 32'h0);
      I = ADD1;
      step();
      chk("held_reset_u1", 32'(all1()), 32'h0);
      @(negedge CLK);
      CLR_N = 1'b1;
      step();
      chk("resume_ex", 32'({alu1, sh1, s1, b1, bl1}), 32'h40);
      I = 32'h0;
      step();
      step();
      chk("resume_wb", 32'({wrf1, wrd1}), 32'h11);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
